abs_diff_err_sweeper: RTL

Sequential evaluation harness that drives an exhaustive input sweep into a pair of combinational circuits (exact reference and approximated candidate) and reads back their outputs. It computes the absolute error per input vector and accumulates the worst-case error and the violation count against the error threshold. It returns a pass/fail verdict. It sits on the test side of every approximated netlist the flow emits, providing in-hardware confirmation of the error bound the synthesis step claims.

---
 rtl/abs_diff_eval_pkg.sv | 21 ++
 rtl/abs_diff_err_unit.sv | 19 +
 rtl/abs_diff_err_sweeper.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/abs_diff_eval_pkg.sv
// Shared types and defaults for the approximate-circuit error sweeper.
package abs_diff_eval_pkg;

    localparam int unsigned DEF_IN_W  = 4;
    localparam int unsigned DEF_OUT_W = 3;
    localparam int unsigned DEF_ET    = 4;
    localparam int unsigned DEF_LAT   = 0;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DRAIN,
        DONE
    } state_t;

    // One extra bit so a full sweep of 2^in_w violations cannot overflow.
    function automatic int unsigned viol_cnt_w(input int unsigned in_w);
        return in_w + 1;
    endfunction

endpackage

// File: rtl/abs_diff_err_unit.sv
// Unsigned |a - b| plus the threshold-violation flag for one response pair.
module abs_diff_err_unit #(
    parameter int unsigned OUT_W = 3,
    parameter int unsigned ET    = 4
) (
    input  logic [OUT_W-1:0] i_a,
    input  logic [OUT_W-1:0] i_b,
    output logic [OUT_W-1:0] o_err,
    output logic             o_viol
);

    logic [OUT_W-1:0] w_err;

    // Subtract the smaller from the larger so the result never wraps.
    assign w_err  = (i_a >= i_b) ? (i_a - i_b) : (i_b - i_a);
    assign o_err  = w_err;
    assign o_viol = (32'(w_err) > ET);

endmodule

// File: rtl/abs_diff_err_sweeper.sv
// Exhaustive stimulus sweep over an exact/approximate circuit pair, tracking
// worst-case error and threshold violations, with a registered pass verdict.
module abs_diff_err_sweeper
    import abs_diff_eval_pkg::*;
#(
    parameter int unsigned IN_W  = DEF_IN_W,
    parameter int unsigned OUT_W = DEF_OUT_W,
    parameter int unsigned ET    = DEF_ET,
    parameter int unsigned LAT   = DEF_LAT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic [IN_W-1:0]             stim,
    output logic                        stim_valid,
    input  logic [OUT_W-1:0]            exact_out,
    input  logic [OUT_W-1:0]            approx_out,
    output logic                        busy,
    output logic                        done,
    output logic [OUT_W-1:0]            max_err,
    output logic [viol_cnt_w(IN_W)-1:0] viol_cnt,
    output logic                        pass
);

    localparam int unsigned CNT_W = viol_cnt_w(IN_W);
    localparam int unsigned DRN_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'((LAT > 0) ? LAT - 1 : 0);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IN_W-1:0]  r_stim;
    logic             r_stim_valid;
    logic [DRN_W-1:0] r_drn_cnt;
    logic [OUT_W-1:0] r_max_err;
    logic [CNT_W-1:0] r_viol_cnt;
    logic             r_pass;

    logic [OUT_W-1:0] w_err;
    logic [OUT_W-1:0] w_max_upd;
    logic             w_viol;
    logic             w_sample;
    logic             w_go;
    logic             w_last_vec;

    abs_diff_err_unit #(
        .OUT_W (OUT_W),
        .ET    (ET)
    ) u_err (
        .i_a    (exact_out),
        .i_b    (approx_out),
        .o_err  (w_err),
        .o_viol (w_viol)
    );

    assign w_go       = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last_vec = (r_stim == '1);

    // Valid tag travels LAT cycles alongside the DUT pipeline so only
    // responses to presented vectors are accumulated.
    generate
        if (LAT == 0) begin : g_nopipe
            assign w_sample = r_stim_valid;
        end else begin : g_pipe
            logic [LAT-1:0] r_vpipe;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vpipe <= '0;
                end else begin
                    r_vpipe <= (r_vpipe << 1) | LAT'(r_stim_valid);
                end
            end
            assign w_sample = r_vpipe[LAT-1];
        end
    endgenerate

    assign w_max_upd = (w_sample && (w_err > r_max_err)) ? w_err : r_max_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE, DONE: if (start)      w_state_nxt = SWEEP;
            SWEEP:      if (w_last_vec) w_state_nxt = (LAT > 0) ? DRAIN : DONE;
            DRAIN:      if (r_drn_cnt == DRN_LAST) w_state_nxt = DONE;
            default:    w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stim       <= '0;
            r_stim_valid <= 1'b0;
            r_drn_cnt    <= '0;
            r_max_err    <= '0;
            r_viol_cnt   <= '0;
            r_pass       <= 1'b0;
        end else begin
            r_drn_cnt <= (r_state == DRAIN) ? r_drn_cnt + 1'b1 : '0;
            if (w_go) begin
                r_stim       <= '0;
                r_stim_valid <= 1'b1;
                r_max_err    <= '0;
                r_viol_cnt   <= '0;
                r_pass       <= 1'b0;
            end else begin
                if (r_state == SWEEP) begin
                    if (w_last_vec) begin
                        r_stim_valid <= 1'b0;
                    end else begin
                        r_stim <= r_stim + 1'b1;
                    end
                end
                if (w_sample) begin
                    r_max_err  <= w_max_upd;
                    r_viol_cnt <= r_viol_cnt + CNT_W'(w_viol);
                end
                // Verdict uses the final sample, which lands on the same edge.
                if ((w_state_nxt == DONE) && (r_state != DONE)) begin
                    r_pass <= (32'(w_max_upd) <= ET);
                end
            end
        end
    end

    assign stim       = r_stim;
    assign stim_valid = r_stim_valid;
    assign busy       = (r_state == SWEEP) || (r_state == DRAIN);
    assign done       = (r_state == DONE);
    assign max_err    = r_max_err;
    assign viol_cnt   = r_viol_cnt;
    assign pass       = r_pass;

endmodule
